// File: rtl/lsu_copy_engine.sv
// Word-copy engine driving one LSU port: READ/WRITE per word, 2 cycles/word; N words -> o_done 2N+1 cycles after start.
// No backpressure, the LSU answers combinationally. Optional fill mode (LSU_COPY_FILL_EN) writes a constant at 1 word/cycle.
module lsu_copy_engine #(
  parameter int LEN_W = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
`ifdef LSU_COPY_FILL_EN
  input  logic             i_fill,
  input  logic [31:0]      i_fill_data,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_words_done,
  output logic [31:0]      o_lsu_addr,
  output logic [31:0]      o_st_data,
  output logic             o_lsu_wren,
  output logic [2:0]       o_funct3,
  input  logic [31:0]      i_ld_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fill_q, fill_d;

  logic             fill_start;
  logic [31:0]      fill_data;
  logic             misaligned;

`ifdef LSU_COPY_FILL_EN
  assign fill_start = i_fill;
  assign fill_data  = i_fill_data;
`else
  assign fill_start = 1'b0;
  assign fill_data  = 32'h0;
`endif

  // Fill never reads, so the source alignment is irrelevant there.
  assign misaligned = (i_dst_addr[1:0] != 2'b00) ||
                      (!fill_start && (i_src_addr[1:0] != 2'b00));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    data_d     = data_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fill_d     = fill_q;
    o_lsu_addr = 32'h0;
    o_lsu_wren = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          src_d  = i_src_addr;
          dst_d  = i_dst_addr;
          rem_d  = i_len;
          cnt_d  = '0;
          err_d  = misaligned;
          fill_d = fill_start;
          if (fill_start) data_d = fill_data;
          if ((i_len == '0) || misaligned) state_d = FINISH;
          else if (fill_start)             state_d = WRITE;
          else                             state_d = READ;
        end
      end
      READ: begin
        o_lsu_addr = src_q;
        data_d     = i_ld_data;
        state_d    = i_abort ? IDLE : WRITE;
      end
      WRITE: begin
        // The store is presented this cycle regardless of abort, so it is always counted.
        o_lsu_addr = dst_q;
        o_lsu_wren = 1'b1;
        src_d      = src_q + 32'd4;
        dst_d      = dst_q + 32'd4;
        cnt_d      = cnt_q + LEN_W'(1);
        rem_d      = rem_q - LEN_W'(1);
        if (i_abort)                  state_d = IDLE;
        else if (rem_q == LEN_W'(1))  state_d = FINISH;
        else if (fill_q)              state_d = WRITE;
        else                          state_d = READ;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == FINISH);
  assign o_err        = (state_q == FINISH) && err_q;
  assign o_words_done = cnt_q;
  assign o_st_data    = data_q;
  assign o_funct3     = 3'b010;

endmodule

// File: tb/tb_lsu_copy_engine.sv
// Bench for lsu_copy_engine: word memory model behind the LSU port, store scoreboard, vector table plus abort/reset sequences.
module tb_lsu_copy_engine;
  localparam int LEN_W = 10;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             fill;
  logic [31:0]      fill_data;
  logic             busy, done, err, wren;
  logic [LEN_W-1:0] words_done;
  logic [31:0]      lsu_addr, st_data, ld_data;
  logic [2:0]       funct3;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;
  st_t sb[$];
  st_t e;

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    logic        fill;
    logic        exp_err;
    int          exp_cyc;
    int          exp_words;
  } vec_t;
  vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  lsu_copy_engine #(.LEN_W(LEN_W)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_src_addr   (src),
    .i_dst_addr   (dst),
    .i_len        (len),
    .i_abort      (abort),
`ifdef LSU_COPY_FILL_EN
    .i_fill       (fill),
    .i_fill_data  (fill_data),
`endif
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_words_done (words_done),
    .o_lsu_addr   (lsu_addr),
    .o_st_data    (st_data),
    .o_lsu_wren   (wren),
    .o_funct3     (funct3),
    .i_ld_data    (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ld_data = mem[lsu_addr[11:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Stores are sampled mid-cycle, checked against the scoreboard, then committed to memory.
  always @(negedge clk) begin
    if (rst_n && wren) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_store actual=%0h:%0h required=none", lsu_addr, st_data);
      end else begin
        e = sb.pop_front();
        if (lsu_addr !== e.addr || st_data !== e.data) begin
          bad++;
          $display("FAIL store actual=%0h:%0h required=%0h:%0h", lsu_addr, st_data, e.addr, e.data);
        end
      end
      mem[lsu_addr[11:2]] = st_data;
    end
  end

  task automatic run_vec(input vec_t v);
    logic [31:0] a;
    logic [31:0] last_dst;
    logic [31:0] last_val;
    logic [31:0] pre_dst;
    int cyc, bsy;
    bit got;
    for (int i = 0; i < v.len; i++) begin
      a = v.src + 32'(4 * i);
      mem[a[11:2]] = $urandom;
    end
    pre_dst  = mem[v.dst[11:2]];
    last_dst = v.dst;
    last_val = pre_dst;
    if (!v.exp_err) begin
      for (int i = 0; i < v.len; i++) begin
        a = v.src + 32'(4 * i);
        e.addr = v.dst + 32'(4 * i);
        e.data = v.fill ? 32'hDEADBEEF : mem[a[11:2]];
        sb.push_back(e);
        last_dst = e.addr;
        last_val = e.data;
      end
    end
    @(negedge clk);
    src = v.src; dst = v.dst; len = LEN_W'(v.len); fill = v.fill; fill_data = 32'hDEADBEEF;
    start = 1'b1;
    cyc = 0; bsy = 0; got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) bsy++;
      if (done) begin
        got = 1;
        chk({v.name, "_err"}, 32'(err), 32'(v.exp_err));
        chk({v.name, "_words"}, 32'(words_done), 32'(v.exp_words));
      end
    end
    chk({v.name, "_got_done"}, 32'(got), 32'd1);
    chk({v.name, "_done_cycle"}, 32'(cyc), 32'(v.exp_cyc));
    chk({v.name, "_busy_cycles"}, 32'(bsy), 32'(v.exp_cyc));
    @(negedge clk);
    chk({v.name, "_done_pulse"}, {30'h0, done, busy}, 32'h0);
    chk({v.name, "_sb_empty"}, 32'(sb.size()), 32'h0);
    chk({v.name, "_mem_last"}, mem[last_dst[11:2]], last_val);
    sb.delete();
  endtask

  initial begin
    vec_t v;
    logic [31:0] pre;
    int cyc;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fill = 1'b0; fill_data = 32'h0;
    src = 32'h0; dst = 32'h0; len = '0;

    vecs.push_back('{"copy4",     32'h100, 32'h200, 4, 1'b0, 1'b0, 9,  4});
    vecs.push_back('{"src_mis",   32'h102, 32'h200, 3, 1'b0, 1'b1, 1,  0});
    vecs.push_back('{"dst_mis",   32'h100, 32'h203, 3, 1'b0, 1'b1, 1,  0});
    vecs.push_back('{"len0",      32'h100, 32'h200, 0, 1'b0, 1'b0, 1,  0});
    vecs.push_back('{"copy1",     32'h400, 32'h800, 1, 1'b0, 1'b0, 3,  1});
    vecs.push_back('{"copy7",     32'h010, 32'hF00, 7, 1'b0, 1'b0, 15, 7});
    vecs.push_back('{"wrap",      32'hFFFF_FFF8, 32'h500, 4, 1'b0, 1'b0, 9, 4});
`ifdef LSU_COPY_FILL_EN
    vecs.push_back('{"fill4",     32'h0,   32'h300, 4, 1'b1, 1'b0, 5,  4});
    vecs.push_back('{"fill_srcmis", 32'h102, 32'h340, 2, 1'b1, 1'b0, 3, 2});
    vecs.push_back('{"fill_dstmis", 32'h100, 32'h342, 2, 1'b1, 1'b1, 1, 0});
`endif

    #12;
    chk("rst_outs", {busy, done, err, wren, 28'h0}, 32'h0);
    chk("rst_words", 32'(words_done), 32'h0);
    chk("rst_addr", lsu_addr, 32'h0);
    chk("rst_st_data", st_data, 32'h0);
    chk("rst_funct3", 32'(funct3), 32'h2);
    @(negedge clk);
    rst_n = 1'b1;

    // abort in IDLE must not start anything
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // abort in 3rd WRITE of len=8, with an ignored start while busy
    for (int i = 0; i < 8; i++) mem[(32'h600 >> 2) + i] = $urandom;
    for (int i = 0; i < 3; i++) begin
      e.addr = 32'hA00 + 32'(4 * i);
      e.data = mem[(32'h600 >> 2) + i];
      sb.push_back(e);
    end
    pre = mem[(32'hA0C >> 2)];
    @(negedge clk);
    src = 32'h600; dst = 32'hA00; len = LEN_W'(8); fill = 1'b0; start = 1'b1;
    cyc = 0;
    repeat (6) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3);
      if (cyc == 3) begin src = 32'h100; dst = 32'h104; len = LEN_W'(2); end
      if (done) chk("abort_no_done_mid", 32'(done), 32'h0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_words", 32'(words_done), 32'h3);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 32'h0);
    chk("abort_sb_empty", 32'(sb.size()), 32'h0);
    chk("abort_mem_4th", mem[(32'hA0C >> 2)], pre);

    // reset during 2nd READ of len=5
    for (int i = 0; i < 5; i++) mem[(32'hC00 >> 2) + i] = $urandom;
    e.addr = 32'hE00;
    e.data = mem[32'hC00 >> 2];
    sb.push_back(e);
    pre = mem[(32'hE04 >> 2)];
    @(negedge clk);
    src = 32'hC00; dst = 32'hE00; len = LEN_W'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_in_read", {lsu_addr[31:1], wren}, {31'(32'hC04 >> 1), 1'b0});
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_outs", {busy, done, err, wren, 28'h0}, 32'h0);
    chk("rstmid_words", 32'(words_done), 32'h0);
    chk("rstmid_addr", lsu_addr, 32'h0);
    chk("rstmid_st_data", st_data, 32'h0);
    chk("rstmid_funct3", 32'(funct3), 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_no_resume", 32'(busy), 32'h0);
    chk("rstmid_sb_empty", 32'(sb.size()), 32'h0);
    chk("rstmid_word0", mem[32'hE00 >> 2], e.data);
    chk("rstmid_word1", mem[32'hE04 >> 2], pre);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_copy_engine.md
LSU_COPY_ENGINE -- requirements
Module: lsu_copy_engine

Interface
REQ-001 SHALL have parameter LEN_W, default 10, giving the word-count width (max transfer 2^LEN_W-1 words).
REQ-002 SHALL have port i_clk  input  1  rising-edge clock.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_start  input  1  single-cycle request to start a transfer; sampled only in IDLE.
REQ-005 SHALL have port i_src_addr  input  32  source byte address of the first word.
REQ-006 SHALL have port i_dst_addr  input  32  destination byte address of the first word.
REQ-007 SHALL have port i_len  input  LEN_W  number of 32-bit words to move.
REQ-008 SHALL have port i_abort  input  1  terminates an active transfer.
REQ-009 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse at normal completion or error.
REQ-011 SHALL have port o_err  output  1  one-cycle pulse, coincident with o_done, for a misaligned request.
REQ-012 SHALL have port o_words_done  output  LEN_W  count of words written in the current or last transfer.
REQ-013 SHALL have port o_lsu_addr  output  32  load/store address to the LSU.
REQ-014 SHALL have port o_st_data  output  32  store data to the LSU.
REQ-015 SHALL have port o_lsu_wren  output  1  store enable to the LSU.
REQ-016 SHALL have port o_funct3  output  3  access size; constant 3'b010 (word).
REQ-017 SHALL have port i_ld_data  input  32  combinational load data returned by the LSU for o_lsu_addr.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, FINISH.
REQ-019 IDLE + i_start: latch src, dst, len; clear o_words_done; go to FINISH if len==0 or src[1:0]!=0 or dst[1:0]!=0, else READ.
REQ-020 READ: drive o_lsu_addr=src pointer, o_lsu_wren=0; at the clock edge capture i_ld_data into a data register; go to WRITE.
REQ-021 WRITE: drive o_lsu_addr=dst pointer, o_st_data=data register, o_lsu_wren=1; at the edge advance both pointers by 4 (mod 2^32), increment o_words_done, decrement remaining; go to FINISH if remaining reaches 0, else READ.
REQ-022 Throughput SHALL be exactly 2 cycles per word; an N-word transfer holds o_busy for 2N+1 cycles after the start edge.
REQ-023 FINISH: assert o_done for one cycle (o_err as well if misaligned); return to IDLE.
REQ-024 Misaligned request SHALL issue no bus transaction; o_lsu_wren stays 0.
REQ-025 len==0 SHALL complete with o_done, o_err=0, no bus transaction.
REQ-026 i_abort in READ or WRITE SHALL return to IDLE at that edge without o_done; a store presented in that WRITE cycle still occurs and is counted.
REQ-027 i_start while o_busy SHALL be ignored; i_abort in IDLE or FINISH SHALL be ignored.
REQ-028 Outside WRITE, o_lsu_wren SHALL be 0 and o_st_data SHALL hold the data register.
REQ-029 In IDLE and FINISH, o_lsu_addr SHALL be 0.

Reset
REQ-030 On i_reset low SHALL enter IDLE asynchronously, including mid-transfer.
REQ-031 Reset values: o_busy=0, o_done=0, o_err=0, o_words_done=0, o_lsu_wren=0, o_lsu_addr=0, o_st_data=0, o_funct3=3'b010.
REQ-032 A transfer interrupted by reset SHALL not resume; stores already issued remain in memory.

Configuration
REQ-033 Macro LSU_COPY_FILL_EN defined: add ports i_fill (input 1) and i_fill_data (input 32), latched at start; fill transfers skip READ, stay in WRITE storing i_fill_data at 1 word/cycle, alignment checked on dst only.
REQ-034 Macro LSU_COPY_FILL_EN undefined: ports i_fill/i_fill_data absent; every transfer is a copy per REQ-019..021.

Verification
REQ-035 src=0x100, dst=0x200, len=4, memory[0x100..0x10C]=A,B,C,D -> 0x200..0x20C=A,B,C,D; o_done at cycle 9 after start; o_words_done=4.
REQ-036 src=0x102, len=3 -> o_done=o_err=1 in one pulse; o_lsu_wren never high; memory unchanged.
REQ-037 len=0 -> o_done pulse, o_err=0, o_words_done=0, no store.
REQ-038 len=8, i_abort in 3rd WRITE cycle -> exactly 3 words copied, o_words_done=3, no o_done, o_busy low next cycle.
REQ-039 i_reset low during 2nd READ of len=5 -> IDLE immediately, all outputs at reset values, 1 word copied.
REQ-040 LSU_COPY_FILL_EN, i_fill=1, i_fill_data=0xDEADBEEF, dst=0x300, len=4 -> 4 stores on consecutive cycles, 0x300..0x30C=0xDEADBEEF, o_done 5 cycles after start.
